// File: rtl/dut_port_arbiter.sv
// Round-robin arbiter/sequencer that serialises single register transactions from
// two requesters onto the shared DUT write/read port, with an optional ready timeout.
module dut_port_arbiter #(
    parameter int ADDR_W  = 3,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_wdata,
    output logic              m0_ack,
    output logic              m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_wdata,
    output logic              m1_ack,
    output logic              m1_rdata,
    output logic              m1_err,
    output logic [ADDR_W-1:0] write_address,
    output logic              write_data,
    output logic              write_en,
    input  logic              write_rdy,
    output logic [ADDR_W-1:0] read_address,
    output logic              read_en,
    input  logic              read_data,
    input  logic              read_rdy,
    output logic              busy,
    output logic              last_grant
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

    localparam logic [16:0] TIMEOUT_L = 17'(TIMEOUT);

    state_t            state_reg, state_next;
    logic              prio_reg, prio_next;
    logic              grant_reg, grant_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              wdata_reg, wdata_next;
    logic [15:0]       cnt_reg, cnt_next;
    logic [1:0]        rdata_reg, err_reg;
    logic [1:0]        ack_vec;

    logic        win;
    logic        fire;
    logic        timeout_hit;
    logic        done;
    logic [16:0] cnt_inc;

    // Pointer only breaks ties; a lone requester always wins.
    assign win     = (m0_req && m1_req) ? prio_reg : m1_req;
    assign fire    = (state_reg == ISSUE) && (we_reg ? write_rdy : read_rdy);
    assign cnt_inc = {1'b0, cnt_reg} + 17'd1;
    assign timeout_hit = (TIMEOUT != 0) && (state_reg == ISSUE) && !fire
                         && (cnt_inc == TIMEOUT_L);
    assign done    = fire || timeout_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            prio_reg  <= 1'b0;
            grant_reg <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= 1'b0;
            cnt_reg   <= '0;
            rdata_reg <= '0;
            err_reg   <= '0;
        end else begin
            state_reg <= state_next;
            prio_reg  <= prio_next;
            grant_reg <= grant_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            cnt_reg   <= cnt_next;
            for (int i = 0; i < 2; i++) begin
                if (done && (grant_reg == 1'(i))) begin
                    rdata_reg[i] <= fire && !we_reg && read_data;
                    err_reg[i]   <= timeout_hit;
                end
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        prio_next  = prio_reg;
        grant_next = grant_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant_next = win;
                    we_next    = win ? m1_we    : m0_we;
                    addr_next  = win ? m1_addr  : m0_addr;
                    wdata_next = win ? m1_wdata : m0_wdata;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (done) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_inc[15:0];
                end
            end
            RESP: begin
                prio_next  = ~grant_reg;
                cnt_next   = '0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        write_en      = (state_reg == ISSUE) && we_reg && write_rdy;
        read_en       = (state_reg == ISSUE) && !we_reg && read_rdy;
        write_address = (state_reg == ISSUE) ? addr_reg : '0;
        read_address  = (state_reg == ISSUE) ? addr_reg : '0;
        write_data    = (state_reg == ISSUE) && wdata_reg;
        busy          = (state_reg != IDLE);
        last_grant    = grant_reg;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ack
            assign ack_vec[gi] = (state_reg == RESP) && (grant_reg == 1'(gi));
        end
    endgenerate

    assign m0_ack   = ack_vec[0];
    assign m0_rdata = rdata_reg[0];
    assign m0_err   = err_reg[0];
    assign m1_ack   = ack_vec[1];
    assign m1_rdata = rdata_reg[1];
    assign m1_err   = err_reg[1];

endmodule
